// File: rtl/imm_ext_sequencer.sv
// Immediate-extension sequencer: decodes an 11-bit immediate field into a 16-bit operand
// behind a registered valid/ready output stage. IMM_PREFIX_EN enables the PREFIX upper-byte sequence.
module imm_ext_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [10:0] in_field,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_imm,
  output logic        out_prefixed,
  output logic        prefix_pending
);

  // Handshake: a transfer happens on a rising edge where valid && ready. A producer holds its
  // payload stable while valid && !ready; ready never depends on the payload of the same side.
  localparam logic [2:0] FMT_SE8    = 3'd0;
  localparam logic [2:0] FMT_ZE8    = 3'd1;
  localparam logic [2:0] FMT_ZE3    = 3'd2;
  localparam logic [2:0] FMT_ZE7    = 3'd3;
  localparam logic [2:0] FMT_ZE5    = 3'd4;
  localparam logic [2:0] FMT_SE6    = 3'd5;
  localparam logic [2:0] FMT_SE11   = 3'd6;

  function automatic logic [15:0] ext_imm(input logic [2:0] fmt, input logic [10:0] x);
    logic [15:0] r;
    case (fmt)
      FMT_SE8:  r = {{8{x[7]}}, x[7:0]};
      FMT_ZE8:  r = {8'h00, x[7:0]};
      FMT_ZE3:  r = {13'h0000, x[2:0]};
      FMT_ZE7:  r = {9'h000, x[6:0]};
      FMT_ZE5:  r = {11'h000, x[4:0]};
      FMT_SE6:  r = {{10{x[5]}}, x[5:0]};
      FMT_SE11: r = {{5{x[10]}}, x[10:0]};
      default:  r = {8'h00, x[7:0]};  // fmt 7 without prefix support behaves as ZE8
    endcase
    return r;
  endfunction

  logic        accept;
  logic [15:0] ext_val;

  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign ext_val  = ext_imm(in_fmt, in_field);

`ifdef IMM_PREFIX_EN
  typedef enum logic {IDLE, PFX} state_t;

  state_t     state;
  logic [7:0] pfx_hi;
  logic       is_pfx;

  assign is_pfx         = (in_fmt == 3'd7);
  assign prefix_pending = (state == PFX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      pfx_hi       <= 8'h00;
      out_valid    <= 1'b0;
      out_imm      <= 16'h0000;
      out_prefixed <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      pfx_hi    <= 8'h00;
      out_valid <= 1'b0;
    end else begin
      if (accept && !is_pfx) begin
        out_valid <= 1'b1;
        if (state == PFX) begin
          out_imm      <= {pfx_hi, ext_val[7:0]};
          out_prefixed <= 1'b1;
        end else begin
          out_imm      <= ext_val;
          out_prefixed <= 1'b0;
        end
        state <= IDLE;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // A prefix only arms the upper byte; the output stage is untouched by it.
      if (accept && is_pfx) begin
        pfx_hi <= in_field[7:0];
        state  <= PFX;
      end
    end
  end
`else
  assign prefix_pending = 1'b0;
  assign out_prefixed   = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_imm   <= 16'h0000;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_imm   <= ext_val;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: doc/imm_ext_sequencer.md
# imm_ext_sequencer

Immediate-extension sequencer sitting between instruction decode and the execute-stage operand mux of the 16-bit core. Each accepted request carries a decoded format code and a raw 11-bit immediate field. The block applies the matching sign/zero extension to 16 bits and returns the result through a registered valid/ready output stage. A two-instruction PREFIX sequence lets software build a full 16-bit constant from an 8-bit upper-byte prefix followed by any immediate-bearing instruction.

## Interface
- No parameters (widths fixed by the ISA: 16-bit data, 11-bit immediate field, 3-bit format).
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- flush  in  1  synchronous pipeline flush (branch redirect)
- in_valid  in  1  decode presents a request
- in_ready  out  1  block accepts the request this cycle
- in_fmt  in  3  extension format code
- in_field  in  11  raw immediate field (LSB-aligned)
- out_valid  out  1  out_imm holds a result
- out_ready  in  1  execute consumes the result
- out_imm  out  16  extended immediate
- out_prefixed  out  1  out_imm was assembled with a prefix byte
- prefix_pending  out  1  a prefix is latched and awaiting its consumer

## Operation
- Formats (x = in_field):
  - 0: SE8, sign-extend x[7:0]; replicate x[7].
  - 1: ZE8, zero-extend x[7:0].
  - 2: ZE3, zero-extend x[2:0].
  - 3: ZE7, zero-extend x[6:0].
  - 4: ZE5, zero-extend x[4:0].
  - 5: SE6, sign-extend x[5:0]; replicate x[5].
  - 6: SE11, sign-extend x[10:0]; replicate x[10].
  - 7: PREFIX.
- Field bits above the selected width are ignored.
- A handshake occurs when in_valid && in_ready. in_ready = !flush && (!out_valid || out_ready).
- State machine: IDLE, PFX.
  - IDLE, fmt 7 accepted: latch pfx_hi = x[7:0] and go to PFX. No output is produced and out_valid is unchanged by this request.
  - IDLE, fmt 0-6 accepted: out_imm = ext(x), out_prefixed = 0.
  - PFX, fmt 7 accepted: pfx_hi is replaced by the new x[7:0]; state stays PFX.
  - PFX, fmt 0-6 accepted: out_imm = {pfx_hi, ext(x)[7:0]}, out_prefixed = 1, then go to IDLE.
- prefix_pending = (state == PFX).
- Output register: out_valid is set on accept of fmt 0-6. It is cleared when out_ready is high and no new fmt 0-6 request is accepted. A simultaneous consume and accept keeps out_valid = 1 and loads the new value (full throughput).
- out_imm and out_prefixed hold their values while out_valid && !out_ready.
- flush: in one cycle it clears out_valid, sets state to IDLE and sets pfx_hi to 0. Any input presented that cycle is dropped; in_ready is 0. out_imm holds its stale value.
- reset: out_valid = 0, out_imm = 0, out_prefixed = 0, state = IDLE, pfx_hi = 0, hence prefix_pending = 0 and in_ready = 1.
- Reset asserted mid-sequence, for example in PFX, discards the prefix.

## Timing
- Latency is 1 cycle: a request accepted at edge N appears on out_imm/out_valid after edge N.
- Throughput is 1 result per cycle while out_ready stays high.
- A PREFIX request consumes one accept cycle and produces no result.
- in_ready is combinational from out_valid, out_ready and flush. There is no combinational path from in_* to out_*.
- Backpressure: with out_valid=1 and out_ready=0, in_ready=0 and a prefix cannot be accepted either.

## Configuration
- IMM_PREFIX_EN defined: PREFIX handling as described, with states IDLE and PFX.
- IMM_PREFIX_EN undefined:
  - fmt 7 decodes as ZE8 and produces a normal result.
  - The state machine and pfx_hi are removed.
  - prefix_pending and out_prefixed are tied to 0.

## Test plan
- Reset, then fmt 0 with field 0x0F0 -> out_imm 0xFFF0 one cycle later, out_prefixed 0.
- Formats 1-6 with field 0x7FF, out_ready high:
  - Results in order: 0x00FF, 0x0007, 0x007F, 0x001F, 0xFFFF, 0xFFFF.
  - One result per cycle.
- fmt 7 field 0x0AB, then fmt 1 field 0x0CD:
  - No output after the prefix; prefix_pending goes to 1.
  - Then out_imm 0xABCD, out_prefixed 1, prefix_pending 0.
- Stall case: out_valid with out_ready low for 3 cycles.
  - in_ready stays 0 and out_imm is stable throughout.
  - Releasing out_ready with a simultaneous new request gives back-to-back results and no bubble.
- Flush cases:
  - fmt 7 field 0x012, then flush together with in_valid fmt 1 field 0x034 -> input dropped, prefix_pending 0.
  - Next fmt 1 field 0x034 -> 0x0034, out_prefixed 0.
- Reset asserted asynchronously mid-cycle while in PFX with out_valid=1 -> out_valid, out_imm and prefix_pending go to 0 immediately.
- With IMM_PREFIX_EN undefined, fmt 7 field 0x1AB -> 0x00AB.
